// File: rtl/controle_tentativas_if.sv
// controle_tentativas_if: comparator flags in, front-panel indicators out.
interface controle_tentativas_if;
    logic       confirmar;
    logic       igual;
    logic       ate3;
    logic       errada;
    logic       aberto;
    logic       dica;
    logic       erro;
    logic       bloqueado;
    logic [2:0] erros_cnt;
    logic [7:0] tempo_restante;
    modport master (
        output confirmar, igual, ate3, errada,
        input  aberto, dica, erro, bloqueado, erros_cnt, tempo_restante
    );
    modport slave (
        input  confirmar, igual, ate3, errada,
        output aberto, dica, erro, bloqueado, erros_cnt, tempo_restante
    );
endinterface

// File: rtl/controle_tentativas.sv
// controle_tentativas: counts wrong attempts, opens the safe on success, locks out after MAX_ERROS failures.
module controle_tentativas #(
    parameter int MAX_ERROS  = 3,
    parameter int T_ABERTO   = 50,
    parameter int T_BLOQUEIO = 100
) (
    input logic clk,
    input logic reset,
    controle_tentativas_if.slave bus
);
    localparam logic [1:0] ESPERA    = 2'd0;
    localparam logic [1:0] ABERTO    = 2'd1;
    localparam logic [1:0] BLOQUEADO = 2'd2;
    localparam logic [7:0] LD_ABERTO = 8'(T_ABERTO - 1);
    localparam logic [7:0] LD_BLOQ   = 8'(T_BLOQUEIO - 1);
    localparam logic [2:0] CNT_MAX   = 3'(MAX_ERROS);

    logic [1:0] r_state, w_next_state;
    logic [7:0] r_timer, w_timer;
    logic [2:0] r_cnt, w_cnt;
    logic       r_aberto, w_aberto;
    logic       r_dica, w_dica;
    logic       r_erro, w_erro;
    logic       r_bloq, w_bloq;
    logic       r_conf_q;
    logic       w_evt, w_fim, w_lim;
    logic [2:0] w_cnt_inc;

    assign w_evt     = bus.confirmar && !r_conf_q;
    assign w_fim     = (r_timer == 8'd0);
    assign w_cnt_inc = r_cnt + 3'd1;
    assign w_lim     = (w_cnt_inc == CNT_MAX);

    // Edge register resets to 1 so a button held through reset release is not an event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ESPERA;
            r_timer  <= 8'd0;
            r_cnt    <= 3'd0;
            r_aberto <= 1'b0;
            r_dica   <= 1'b0;
            r_erro   <= 1'b0;
            r_bloq   <= 1'b0;
            r_conf_q <= 1'b1;
        end else begin
            r_state  <= w_next_state;
            r_timer  <= w_timer;
            r_cnt    <= w_cnt;
            r_aberto <= w_aberto;
            r_dica   <= w_dica;
            r_erro   <= w_erro;
            r_bloq   <= w_bloq;
            r_conf_q <= bus.confirmar;
        end
    end

    always_comb begin
        w_next_state = ESPERA;
        case (r_state)
            ESPERA:    w_next_state = !w_evt ? ESPERA : bus.igual ? ABERTO : w_lim ? BLOQUEADO : ESPERA;
            ABERTO:    w_next_state = w_fim ? ESPERA : ABERTO;
            BLOQUEADO: w_next_state = w_fim ? ESPERA : BLOQUEADO;
            default:   w_next_state = ESPERA;
        endcase
    end

    always_comb begin
        w_timer  = r_timer;
        w_cnt    = r_cnt;
        w_aberto = r_aberto;
        w_dica   = r_dica;
        w_erro   = r_erro;
        w_bloq   = r_bloq;
        case (r_state)
            ESPERA: begin
                if (w_evt && bus.igual) begin
                    w_aberto = 1'b1;
                    w_timer  = LD_ABERTO;
                    w_cnt    = 3'd0;
                    w_erro   = 1'b0;
                    w_dica   = 1'b0;
                end else if (w_evt) begin
                    w_erro  = 1'b1;
                    w_dica  = bus.ate3;
                    w_cnt   = w_cnt_inc;
                    w_bloq  = w_lim;
                    w_timer = w_lim ? LD_BLOQ : r_timer;
                end
            end
            ABERTO: begin
                w_timer  = w_fim ? 8'd0 : r_timer - 8'd1;
                w_aberto = !w_fim;
            end
            BLOQUEADO: begin
                w_timer = w_fim ? 8'd0 : r_timer - 8'd1;
                w_bloq  = !w_fim;
                w_cnt   = w_fim ? 3'd0 : r_cnt;
                w_erro  = w_fim ? 1'b0 : r_erro;
                w_dica  = w_fim ? 1'b0 : r_dica;
            end
            default: begin
                w_timer  = 8'd0;
                w_cnt    = 3'd0;
                w_aberto = 1'b0;
                w_dica   = 1'b0;
                w_erro   = 1'b0;
                w_bloq   = 1'b0;
            end
        endcase
    end

    assign bus.aberto         = r_aberto;
    assign bus.dica           = r_dica;
    assign bus.erro           = r_erro;
    assign bus.bloqueado      = r_bloq;
    assign bus.erros_cnt      = r_cnt;
    assign bus.tempo_restante = r_timer;
endmodule

// File: tb/tb_controle_tentativas.sv
// tb_controle_tentativas: directed scoreboard bench with MAX_ERROS=3, T_ABERTO=4, T_BLOQUEIO=6.
module tb_controle_tentativas;
    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [14:0] exp_q[$];

    controle_tentativas_if bus();

    controle_tentativas #(.MAX_ERROS(3), .T_ABERTO(4), .T_BLOQUEIO(6)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {aberto, dica, erro, bloqueado, erros_cnt, tempo_restante}
    function automatic logic [14:0] pk(logic a, logic d, logic e, logic b, logic [2:0] c, logic [7:0] t);
        return {a, d, e, b, c, t};
    endfunction

    function automatic logic [14:0] obs();
        return {bus.aberto, bus.dica, bus.erro, bus.bloqueado, bus.erros_cnt, bus.tempo_restante};
    endfunction

    task automatic chk(input string tag, input logic [14:0] e);
        logic [14:0] o;
        o = obs();
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s got a=%b d=%b e=%b b=%b cnt=%0d t=%0d exp a=%b d=%b e=%b b=%b cnt=%0d t=%0d",
                   tag, o[14], o[13], o[12], o[11], o[10:8], o[7:0], e[14], e[13], e[12], e[11], e[10:8], e[7:0]);
        end
    endtask

    // Drive inputs just after an edge, queue the expected post-edge outputs, check after the next edge.
    task automatic cyc(input logic c, input logic g, input logic a3, input logic er, input logic [14:0] e, input string tag);
        bus.confirmar = c;
        bus.igual     = g;
        bus.ate3      = a3;
        bus.errada    = er;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        chk(tag, exp_q.pop_front());
    endtask

    initial begin
        logic [14:0] z;
        z = pk(0, 0, 0, 0, 3'd0, 8'd0);
        total = 0;
        bad = 0;
        reset = 1'b1;
        bus.confirmar = 1'b0;
        bus.igual = 1'b0;
        bus.ate3 = 1'b0;
        bus.errada = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", z);
        reset = 1'b0;
        cyc(0, 0, 0, 0, z, "idle0");
        cyc(1, 1, 0, 0, pk(1, 0, 0, 0, 3'd0, 8'd3), "open3");
        cyc(0, 0, 0, 0, pk(1, 0, 0, 0, 3'd0, 8'd2), "open2");
        cyc(0, 0, 0, 0, pk(1, 0, 0, 0, 3'd0, 8'd1), "open1");
        cyc(0, 0, 0, 0, pk(1, 0, 0, 0, 3'd0, 8'd0), "open0");
        cyc(0, 0, 0, 0, z, "closed");
        cyc(1, 0, 1, 0, pk(0, 1, 1, 0, 3'd1, 8'd0), "wrong1");
        cyc(0, 0, 0, 0, pk(0, 1, 1, 0, 3'd1, 8'd0), "hold1");
        cyc(1, 0, 0, 1, pk(0, 0, 1, 0, 3'd2, 8'd0), "wrong2");
        cyc(0, 0, 0, 0, pk(0, 0, 1, 0, 3'd2, 8'd0), "hold2");
        cyc(1, 0, 0, 0, pk(0, 0, 1, 1, 3'd3, 8'd5), "lock5");
        cyc(0, 1, 0, 0, pk(0, 0, 1, 1, 3'd3, 8'd4), "lock4");
        cyc(1, 1, 0, 0, pk(0, 0, 1, 1, 3'd3, 8'd3), "lock3_ign");
        cyc(0, 1, 0, 0, pk(0, 0, 1, 1, 3'd3, 8'd2), "lock2");
        cyc(1, 1, 0, 0, pk(0, 0, 1, 1, 3'd3, 8'd1), "lock1_ign");
        cyc(0, 0, 0, 0, pk(0, 0, 1, 1, 3'd3, 8'd0), "lock0");
        cyc(0, 0, 0, 0, z, "unlock");
        cyc(1, 0, 0, 1, pk(0, 0, 1, 0, 3'd1, 8'd0), "w_a1");
        cyc(0, 0, 0, 0, pk(0, 0, 1, 0, 3'd1, 8'd0), "w_a1h");
        cyc(1, 0, 1, 1, pk(0, 1, 1, 0, 3'd2, 8'd0), "w_a2");
        cyc(0, 0, 0, 0, pk(0, 1, 1, 0, 3'd2, 8'd0), "w_a2h");
        cyc(1, 1, 1, 1, pk(1, 0, 0, 0, 3'd0, 8'd3), "igual_prio");
        cyc(0, 0, 0, 0, pk(1, 0, 0, 0, 3'd0, 8'd2), "op2");
        cyc(0, 0, 0, 0, pk(1, 0, 0, 0, 3'd0, 8'd1), "op1");
        cyc(0, 0, 0, 0, pk(1, 0, 0, 0, 3'd0, 8'd0), "op0");
        cyc(0, 0, 0, 0, z, "cl");
        cyc(1, 0, 0, 1, pk(0, 0, 1, 0, 3'd1, 8'd0), "w_after_open");
        cyc(0, 0, 0, 0, pk(0, 0, 1, 0, 3'd1, 8'd0), "w_after_open_h");
        reset = 1'b1;
        #1;
        chk("reset2", z);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(0, 0, 0, 0, z, "idle1");
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 1, pk(0, 0, 1, 0, 3'd1, 8'd0), "held");
        cyc(0, 0, 0, 1, pk(0, 0, 1, 0, 3'd1, 8'd0), "held_rel");
        bus.confirmar = 1'b1;
        reset = 1'b1;
        #1;
        chk("reset_held", z);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, z, "held_thru_reset");
        cyc(0, 0, 0, 0, z, "idle2");
        cyc(1, 0, 0, 1, pk(0, 0, 1, 0, 3'd1, 8'd0), "l_w1");
        cyc(0, 0, 0, 0, pk(0, 0, 1, 0, 3'd1, 8'd0), "l_w1h");
        cyc(1, 0, 1, 0, pk(0, 1, 1, 0, 3'd2, 8'd0), "l_w2");
        cyc(0, 0, 0, 0, pk(0, 1, 1, 0, 3'd2, 8'd0), "l_w2h");
        cyc(1, 0, 1, 0, pk(0, 1, 1, 1, 3'd3, 8'd5), "l_lock5");
        cyc(0, 0, 0, 0, pk(0, 1, 1, 1, 3'd3, 8'd4), "l_lock4");
        cyc(0, 0, 0, 0, pk(0, 1, 1, 1, 3'd3, 8'd3), "l_lock3");
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset", z);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset", z);
        cyc(0, 0, 0, 0, z, "idle3");
        cyc(1, 1, 0, 0, pk(1, 0, 0, 0, 3'd0, 8'd3), "reopen3");
        cyc(0, 0, 0, 0, pk(1, 0, 0, 0, 3'd0, 8'd2), "reopen2");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
